instr_mem_loadable: RTL and testbench
=====================================

INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 Parameter ADDR_W, default 8: instruction address width.
REQ-002 Parameter DATA_W, default 8: instruction word width.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of words; DEPTH SHALL be at most 2**ADDR_W.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_req  input  1  fetch request, sampled each cycle.
REQ-007 fetch_addr  input  ADDR_W  fetch address.
REQ-008 instr  output  DATA_W  registered fetch data.
REQ-009 instr_valid  output  1  instr holds the data for the previous cycle's accepted fetch.
REQ-010 busy  output  1  high while a program load is in progress.
REQ-011 load_start  input  1  one-cycle pulse that begins a program load.
REQ-012 load_base  input  ADDR_W  first write address, captured on load_start.
REQ-013 load_len  input  ADDR_W+1  word count, captured on load_start.
REQ-014 load_data  input  DATA_W  word to write.
REQ-015 load_valid  input  1  load_data is valid.
REQ-016 load_ready  output  1  block accepts a word this cycle.
REQ-017 load_done  output  1  one-cycle pulse when the load completes.

Function
REQ-018 The block SHALL have FSM states IDLE and LOAD.
REQ-019 In IDLE, fetch_req=1 SHALL read mem[fetch_addr mod DEPTH] into instr and set instr_valid=1 on the next cycle (1-cycle latency).
REQ-020 In IDLE with fetch_req=0, instr_valid SHALL be 0 on the next cycle and instr SHALL hold its last value.
REQ-021 IDLE->LOAD on load_start=1: capture load_base into the write pointer and load_len into the remaining-count register.
REQ-022 load_start with load_len=0 SHALL stay in IDLE and pulse load_done on the next cycle.
REQ-023 In LOAD: busy=1, load_ready=1, fetch_req ignored, instr_valid=0.
REQ-024 In LOAD, each cycle with load_valid=1 SHALL write load_data to mem[ptr], increment ptr and decrement the remaining count.
REQ-025 ptr SHALL wrap from DEPTH-1 to 0.
REQ-026 The cycle that writes the last word SHALL return the FSM to IDLE and pulse load_done on the next cycle.
REQ-027 In IDLE: busy=0, load_ready=0, and load_valid is ignored.
REQ-028 load_start during LOAD SHALL be ignored.
REQ-029 fetch_req and load_start in the same IDLE cycle: serve the fetch (instr_valid=1 next cycle) and enter LOAD.
REQ-030 The first fetch after load_done SHALL return the newly written data.

Reset
REQ-031 rst=1 SHALL force: FSM=IDLE, instr=0, instr_valid=0, busy=0, load_ready=0, load_done=0, ptr=0, count=0.
REQ-032 rst during LOAD SHALL abort the load; words already written remain, and load_done SHALL NOT pulse.
REQ-033 rst SHALL NOT alter memory contents.
REQ-034 Initial memory contents SHALL be the boot image; all other words SHALL be 0.
REQ-035 Boot image, word 0: 8'b000_001_01.
REQ-036 Boot image, word 1: 8'b101_001_00.
REQ-037 Boot image, word 2: 8'b100_010_00.
REQ-038 Boot image, word 3: 8'b110_000_00.

Structure
REQ-039 A shared package SHALL hold the FSM state typedef, the boot-image constants and the opcode field constants (ADD=000, LOAD=100, STORE=101, JMP=110).
REQ-040 The storage array SHALL be one sub-module, imem_array: 1 write port and 1 synchronous read port, with the boot image applied at initialisation. FSM and counters SHALL live in the top.

Verification
REQ-041 After rst, fetch addr 0..3 on consecutive cycles -> instr = 8'h05, 8'hA4, 8'h88, 8'hC0, each one cycle after its request, instr_valid=1.
REQ-042 load_start, base=8'h10, len=3, data 8'hAA, 8'hBB, 8'hCC with one load_valid gap -> load_done one cycle after the 3rd write; fetch 8'h10..8'h12 returns AA, BB, CC.
REQ-043 base=8'hFE, len=4, data 1,2,3,4 -> mem[FE]=1, mem[FF]=2, mem[00]=3, mem[01]=4 (wrap).
REQ-044 fetch_req during LOAD -> instr_valid=0 throughout, busy=1; second load_start ignored.
REQ-045 rst after 2 of 5 words -> busy=0 next cycle, no load_done pulse; the 2 written words are readable.
REQ-046 load_len=0 -> load_done one cycle later, busy never asserted, memory unchanged.

Source files
------------

// File: rtl/instr_mem_loadable_pkg.sv
// rtl/instr_mem_loadable_pkg.sv - shared FSM state, opcode fields and boot image for the loadable instruction memory
package instr_mem_loadable_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JMP   = 3'b110;

  localparam logic [7:0] BOOT_W0 = {OP_ADD,   3'b001, 2'b01};
  localparam logic [7:0] BOOT_W1 = {OP_STORE, 3'b001, 2'b00};
  localparam logic [7:0] BOOT_W2 = {OP_LOAD,  3'b010, 2'b00};
  localparam logic [7:0] BOOT_W3 = {OP_JMP,   3'b000, 2'b00};

  function automatic logic [7:0] boot_word(input int idx);
    case (idx)
      0:       return BOOT_W0;
      1:       return BOOT_W1;
      2:       return BOOT_W2;
      3:       return BOOT_W3;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage: one write port, one registered read port, boot image at power-up
module imem_array
  import instr_mem_loadable_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] words [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Words carry their boot value as a power-up value only; rst never touches them.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam logic [DATA_W-1:0] INIT = DATA_W'(boot_word(i));
    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] word_q = INIT;

    always_comb begin
      word_d = word_q;
      if (we && (waddr == ADDR_W'(i))) begin
        word_d = wdata;
      end
    end

    always_ff @(posedge clk) begin
      word_q <= word_d;
    end

    assign words[i] = word_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = words[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - instruction memory with 1-cycle fetch port and streamed program loader
module instr_mem_loadable
  import instr_mem_loadable_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              busy,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              valid_d, valid_q;
  logic              done_d, done_q;
  logic              rd_en;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = ADDR_W'(32'(fetch_addr) % DEPTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_req) begin
          rd_en   = 1'b1;
          valid_d = 1'b1;
        end
        if (load_start) begin
          if (load_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            ptr_d   = ADDR_W'(32'(load_base) % DEPTH);
            count_d = load_len;
          end
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          wr_en   = ~rst;
          ptr_d   = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_ONE;
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  imem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_imem_array (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(ptr_q),
    .wdata(load_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(instr)
  );

  assign instr_valid = valid_q;
  assign load_done   = done_q;
  assign busy        = (state_q == ST_LOAD);
  assign load_ready  = (state_q == ST_LOAD);

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - randomized self-checking bench for instr_mem_loadable against an array model
module tb_instr_mem_loadable;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [7:0] instr;
  logic       instr_valid;
  logic       busy;
  logic       load_start;
  logic [7:0] load_base;
  logic [8:0] load_len;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_ready;
  logic       load_done;

  int vecs = 0;
  int errs = 0;
  logic [7:0] model [256];

  always #5 clk = ~clk;

  instr_mem_loadable dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .instr(instr), .instr_valid(instr_valid), .busy(busy),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .load_done(load_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vecs++;
    if ({instr, instr_valid, busy, load_ready, load_done} !== 12'h000) begin
      errs++;
      $display("FAIL reset instr=%h valid=%b busy=%b ready=%b done=%b required all zero",
               instr, instr_valid, busy, load_ready, load_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_boot_fetch();
    logic [7:0] boot [4];
    boot = '{8'h05, 8'hA4, 8'h88, 8'hC0};
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1;
      fetch_addr = 8'(i);
      tick();
      vecs++;
      if (instr !== boot[i] || instr_valid !== 1'b1) begin
        errs++;
        $display("FAIL boot_fetch[%0d] instr=%h valid=%b required %h/1", i, instr, instr_valid, boot[i]);
      end
    end
    fetch_req = 1'b0;
    fetch_addr = 8'h04;
    tick();
    vecs++;
    if (instr !== 8'hC0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL fetch_idle_hold instr=%h valid=%b required c0/0", instr, instr_valid);
    end
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    vecs++;
    if (instr !== 8'h00) begin
      errs++;
      $display("FAIL boot_zero instr=%h required 00", instr);
    end
  endtask

  task automatic test_load_gap();
    logic [7:0] d [3];
    logic       pat [4];
    int         w;
    d = '{8'hAA, 8'hBB, 8'hCC};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    w = 0;
    load_start = 1'b1; load_base = 8'h10; load_len = 9'd3;
    tick();
    load_start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || load_ready !== 1'b1) begin
      errs++;
      $display("FAIL load_enter busy=%b ready=%b required 1/1", busy, load_ready);
    end
    for (int c = 0; c < 4; c++) begin
      load_valid = pat[c];
      load_data = pat[c] ? d[w] : 8'h55;
      tick();
      if (pat[c]) begin
        model[8'h10 + w] = d[w];
        w++;
      end
      vecs++;
      if (load_done !== (w == 3 && pat[c]) || busy !== (w != 3) || instr_valid !== 1'b0) begin
        errs++;
        $display("FAIL load_gap[%0d] done=%b busy=%b valid=%b required %b/%b/0",
                 c, load_done, busy, instr_valid, (w == 3), (w != 3));
      end
    end
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'h10 + 8'(i);
      tick();
      vecs++;
      if (instr !== d[i] || instr_valid !== 1'b1 || load_done !== 1'b0) begin
        errs++;
        $display("FAIL load_gap_fetch[%0d] instr=%h valid=%b done=%b required %h/1/0",
                 i, instr, instr_valid, load_done, d[i]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_wrap();
    load_start = 1'b1; load_base = 8'hFE; load_len = 9'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 8'(i + 1);
      tick();
      model[8'(8'hFE + i)] = 8'(i + 1);
    end
    load_valid = 1'b0;
    vecs++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL wrap_done done=%b busy=%b required 1/0", load_done, busy);
    end
    for (int i = 0; i < 5; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'(8'hFE + i);
      tick();
      vecs++;
      if (instr !== model[fetch_addr]) begin
        errs++;
        $display("FAIL wrap_fetch[%h] instr=%h required %h", fetch_addr, instr, model[fetch_addr]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_fetch_during_load();
    fetch_req = 1'b1; fetch_addr = 8'h03;
    load_start = 1'b1; load_base = 8'h20; load_len = 9'd2;
    tick();
    vecs++;
    if (instr !== model[3] || instr_valid !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL fetch_and_start instr=%h valid=%b busy=%b required %h/1/1",
               instr, instr_valid, busy, model[3]);
    end
    load_base = 8'h40; load_len = 9'd5; fetch_addr = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      vecs++;
      if (instr_valid !== 1'b0 || busy !== 1'b1 || load_ready !== 1'b1) begin
        errs++;
        $display("FAIL fetch_in_load[%0d] valid=%b busy=%b ready=%b required 0/1/1",
                 c, instr_valid, busy, load_ready);
      end
    end
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h5A;
    tick();
    model[8'h20] = 8'h5A;
    load_data = 8'hA5;
    tick();
    model[8'h21] = 8'hA5;
    load_valid = 1'b0;
    vecs++;
    if (load_done !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      errs++;
      $display("FAIL second_start_ignored done=%b busy=%b valid=%b required 1/0/0",
               load_done, busy, instr_valid);
    end
    fetch_addr = 8'h20;
    tick();
    vecs++;
    if (instr !== 8'h5A || instr_valid !== 1'b1) begin
      errs++;
      $display("FAIL fetch_after_done instr=%h valid=%b required 5a/1", instr, instr_valid);
    end
    fetch_addr = 8'h40;
    tick();
    fetch_req = 1'b0;
    vecs++;
    if (instr !== model[8'h40] || busy !== 1'b0) begin
      errs++;
      $display("FAIL ignored_base_untouched instr=%h busy=%b required %h/0", instr, busy, model[8'h40]);
    end
  endtask

  task automatic test_reset_abort();
    load_start = 1'b1; load_base = 8'h30; load_len = 9'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 8'hE0 + 8'(i);
      tick();
      model[8'h30 + i] = 8'hE0 + 8'(i);
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecs++;
    if (busy !== 1'b0 || load_done !== 1'b0 || load_ready !== 1'b0) begin
      errs++;
      $display("FAIL abort busy=%b done=%b ready=%b required 0/0/0", busy, load_done, load_ready);
    end
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = 8'h30 + 8'(i);
      tick();
      vecs++;
      if (instr !== model[fetch_addr] || load_done !== 1'b0) begin
        errs++;
        $display("FAIL abort_fetch[%h] instr=%h done=%b required %h/0",
                 fetch_addr, instr, load_done, model[fetch_addr]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_zero_len();
    load_start = 1'b1; load_base = 8'h50; load_len = 9'd0;
    tick();
    load_start = 1'b0;
    vecs++;
    if (load_done !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL zero_len_done done=%b busy=%b required 1/0", load_done, busy);
    end
    load_valid = 1'b1; load_data = 8'h77;
    fetch_req = 1'b1; fetch_addr = 8'h50;
    tick();
    load_valid = 1'b0; fetch_req = 1'b0;
    vecs++;
    if (load_done !== 1'b0 || busy !== 1'b0 || instr !== model[8'h50]) begin
      errs++;
      $display("FAIL zero_len_after done=%b busy=%b instr=%h required 0/0/%h",
               load_done, busy, instr, model[8'h50]);
    end
  endtask

  task automatic test_random();
    for (int op = 0; op < 40; op++) begin
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] base;
        int len, w, guard;
        base = 8'($urandom);
        len = $urandom_range(1, 6);
        w = 0; guard = 0;
        load_start = 1'b1; load_base = base; load_len = 9'(len);
        tick();
        load_start = 1'b0;
        while (w < len && guard < 200) begin
          guard++;
          load_valid = ($urandom_range(0, 3) != 0);
          load_data = 8'($urandom);
          fetch_req = 1'($urandom);
          tick();
          if (load_valid) begin
            model[8'(base + w)] = load_data;
            w++;
          end
          vecs++;
          if (load_done !== (load_valid && w == len) || busy !== (w != len) || instr_valid !== 1'b0) begin
            errs++;
            $display("FAIL rand_load[%0d] done=%b busy=%b valid=%b required %b/%b/0",
                     op, load_done, busy, instr_valid, (load_valid && w == len), (w != len));
          end
        end
        load_valid = 1'b0;
        fetch_req = 1'b0;
      end else begin
        fetch_req = 1'b1;
        fetch_addr = 8'($urandom);
        tick();
        fetch_req = 1'b0;
        vecs++;
        if (instr !== model[fetch_addr] || instr_valid !== 1'b1) begin
          errs++;
          $display("FAIL rand_fetch[%h] instr=%h valid=%b required %h/1",
                   fetch_addr, instr, instr_valid, model[fetch_addr]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    model[0] = 8'h05; model[1] = 8'hA4; model[2] = 8'h88; model[3] = 8'hC0;
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_base = '0; load_len = '0; load_data = '0; load_valid = 1'b0;
    test_reset();
    test_boot_fetch();
    test_load_gap();
    test_wrap();
    test_fetch_during_load();
    test_reset_abort();
    test_zero_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
